// File: rtl/uart_sdram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_sdram_pkg
// Description : Shared FSM encoding and command/burst defaults for the packer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_sdram_pkg;

    localparam int         c_burst_len_def = 4;
    localparam logic [7:0] c_cmd_wr_def    = 8'h55;
    localparam logic [7:0] c_cmd_rd_def    = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_COLLECT = 3'd1,
        ST_WR_TRIG    = 3'd2,
        ST_WR_DRAIN   = 3'd3,
        ST_RD_TRIG    = 3'd4,
        ST_RD_COLLECT = 3'd5,
        ST_RD_SEND    = 3'd6,
        ST_RD_WAIT    = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/packer_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : packer_timeout
// Description : Inter-byte idle counter; expire flags TIMEOUT-1 idle clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module packer_timeout #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int                  c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Saturates at the terminal value so a stalled caller never sees a wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en && !expire) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign expire = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_sdram_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_sdram_packer
// Description : Packs UART command frames into SDRAM write/read bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sdram_packer
    import uart_sdram_pkg::*;
#(
    parameter int         BURST_LEN = c_burst_len_def,
    parameter logic [7:0] CMD_WR    = c_cmd_wr_def,
    parameter logic [7:0] CMD_RD    = c_cmd_rd_def,
    parameter int         TIMEOUT   = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_trig,
    input  logic        wr_req,
    output logic [15:0] wr_data,
    output logic        rd_trig,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        drop
);

    localparam int c_nbytes = 2 * BURST_LEN;
    localparam int c_byte_w = $clog2(c_nbytes);
    localparam int c_ptr_w  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [c_byte_w-1:0] c_last_byte = c_byte_w'(c_nbytes - 1);
    localparam logic [c_ptr_w-1:0]  c_last_word = c_ptr_w'(BURST_LEN - 1);

    state_t              r_state;
    logic [c_byte_w-1:0] r_byte_idx;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic                r_wr_trig;
    logic                r_rd_trig;
    logic                r_tx_start;
    logic [7:0]          r_tx_data;
    logic                r_wait_skip;
    logic                r_loaded;
    logic [7:0]          r_buf [0:c_nbytes-1];

    logic w_wr_store;
    logic w_rd_store;
    logic w_to_clr;
    logic w_to_en;
    logic w_expire;

    assign w_wr_store = (r_state == ST_WR_COLLECT) && rx_valid;
    assign w_rd_store = (r_state == ST_RD_COLLECT) && rd_valid;
    assign w_to_en    = (r_state == ST_WR_COLLECT);
    assign w_to_clr   = !w_to_en || rx_valid;

    packer_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_to_clr),
        .en     (w_to_en),
        .expire (w_expire)
    );

    // Byte-addressed buffer shared by both directions; never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_store) begin
            r_buf[r_byte_idx] <= rx_data;
        end
        if (!rst && w_rd_store) begin
            r_buf[{r_rd_ptr, 1'b0}] <= rd_data[15:8];
            r_buf[{r_rd_ptr, 1'b1}] <= rd_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_byte_idx  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_wr_trig   <= 1'b0;
            r_rd_trig   <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_wait_skip <= 1'b0;
            r_loaded    <= 1'b0;
        end else begin
            r_wr_trig  <= 1'b0;
            r_rd_trig  <= 1'b0;
            r_tx_start <= 1'b0;
            if (w_wr_store || w_rd_store) begin
                r_loaded <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == CMD_WR)) begin
                        r_state    <= ST_WR_COLLECT;
                        r_byte_idx <= '0;
                    end else if (rx_valid && (rx_data == CMD_RD)) begin
                        r_state   <= ST_RD_TRIG;
                        r_rd_trig <= 1'b1;
                        r_rd_ptr  <= '0;
                    end
                end
                ST_WR_COLLECT: begin
                    // A byte arriving on the expiry cycle still wins.
                    if (rx_valid) begin
                        if (r_byte_idx == c_last_byte) begin
                            r_state   <= ST_WR_TRIG;
                            r_wr_trig <= 1'b1;
                        end else begin
                            r_byte_idx <= r_byte_idx + c_byte_w'(1);
                        end
                    end else if (w_expire) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WR_TRIG: begin
                    r_state  <= ST_WR_DRAIN;
                    r_wr_ptr <= '0;
                end
                ST_WR_DRAIN: begin
                    if (wr_req) begin
                        if (r_wr_ptr == c_last_word) begin
                            r_wr_ptr <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                        end
                    end
                end
                ST_RD_TRIG: begin
                    r_state <= ST_RD_COLLECT;
                end
                ST_RD_COLLECT: begin
                    if (rd_valid) begin
                        if (r_rd_ptr == c_last_word) begin
                            r_rd_ptr   <= '0;
                            r_byte_idx <= '0;
                            r_state    <= ST_RD_SEND;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                        end
                    end
                end
                ST_RD_SEND: begin
                    if (!tx_busy) begin
                        r_tx_data   <= r_buf[r_byte_idx];
                        r_tx_start  <= 1'b1;
                        r_wait_skip <= 1'b1;
                        r_state     <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // The transmitter may not raise busy until after tx_start.
                    if (r_wait_skip) begin
                        r_wait_skip <= 1'b0;
                    end else if (!tx_busy) begin
                        if (r_byte_idx == c_last_byte) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + c_byte_w'(1);
                            r_state    <= ST_RD_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_trig  = r_wr_trig;
    assign rd_trig  = r_rd_trig;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign wr_data  = r_loaded ? {r_buf[{r_wr_ptr, 1'b0}], r_buf[{r_wr_ptr, 1'b1}]} : 16'h0000;
    assign busy     = !rst && (r_state != ST_IDLE);
    assign drop     = !rst && rx_valid && (r_state != ST_IDLE) && (r_state != ST_WR_COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_uart_sdram_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_sdram_packer
// Description : Randomised self-checking bench for uart_sdram_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_sdram_packer;

    localparam int BL = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        tx_busy = 1'b0;
    logic        wr_trig, rd_trig, tx_start, busy, drop;
    logic [15:0] wr_data;
    logic [7:0]  tx_data;

    int checks = 0;
    int passed = 0;

    int wr_trig_cnt = 0, rd_trig_cnt = 0, tx_start_cnt = 0;
    int clash_cnt = 0, busy_viol = 0, drop_cnt = 0;
    logic [7:0] tx_q [$];
    logic [7:0] frame [2*BL];

    uart_sdram_packer #(
        .BURST_LEN (BL),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wr_trig  (wr_trig),
        .wr_req   (wr_req),
        .wr_data  (wr_data),
        .rd_trig  (rd_trig),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .busy     (busy),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles and captures transmitted bytes.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_trig === 1'b1) wr_trig_cnt++;
            if (rd_trig === 1'b1) rd_trig_cnt++;
            if (drop === 1'b1) drop_cnt++;
            if ((int'(wr_trig === 1'b1) + int'(rd_trig === 1'b1) + int'(tx_start === 1'b1)) > 1) clash_cnt++;
            if (tx_start === 1'b1) begin
                tx_start_cnt++;
                tx_q.push_back(tx_data);
                if (tx_busy !== 1'b0) busy_viol++;
            end
        end
    end

    // UART transmitter model: busy for a random span after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'($urandom);
        wr_req = 1'b1;
        rd_valid = 1'b1;
        idle(3);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (drop !== 1'b0) $display("FAIL reset_drop: got %b want 0", drop); else passed++;
        checks++; if (wr_trig !== 1'b0) $display("FAIL reset_wr_trig: got %b want 0", wr_trig); else passed++;
        checks++; if (rd_trig !== 1'b0) $display("FAIL reset_rd_trig: got %b want 0", rd_trig); else passed++;
        checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else passed++;
        checks++; if (wr_data !== 16'h0000) $display("FAIL reset_wr_data: got %h want 0000", wr_data); else passed++;
        checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
        rx_valid = 1'b0;
        wr_req = 1'b0;
        rd_valid = 1'b0;
        rst = 1'b0;
        idle(2);
    endtask

    // gap < 0 selects random inter-byte gaps; otherwise a fixed gap is used.
    task automatic run_write(input string name, input int gap);
        int t_wr, t_rd;
        logic [15:0] hold;
        t_wr = wr_trig_cnt;
        t_rd = rd_trig_cnt;
        send_byte(8'h55);
        for (int i = 0; i < 2*BL; i++) begin
            idle((gap < 0) ? int'($urandom_range(0, 3)) : gap);
            if (i == 1) wr_req = 1'b1;
            send_byte(frame[i]);
            wr_req = 1'b0;
        end
        checks++; if (wr_trig !== 1'b1) $display("FAIL %s wr_trig_high: got %b want 1", name, wr_trig); else passed++;
        idle(1);
        checks++; if (wr_trig !== 1'b0) $display("FAIL %s wr_trig_low: got %b want 0", name, wr_trig); else passed++;
        checks++; if (wr_trig_cnt - t_wr !== 1) $display("FAIL %s wr_trig_count: got %0d want 1", name, wr_trig_cnt - t_wr); else passed++;
        for (int k = 0; k < BL; k++) begin
            idle($urandom_range(0, 2));
            wr_req = 1'b1;
            checks++;
            if (wr_data !== {frame[2*k], frame[2*k+1]})
                $display("FAIL %s wr_data[%0d]: got %h want %h", name, k, wr_data, {frame[2*k], frame[2*k+1]});
            else passed++;
            @(posedge clk);
            #1 wr_req = 1'b0;
        end
        checks++; if (busy !== 1'b0) $display("FAIL %s busy_after_drain: got %b want 0", name, busy); else passed++;
        hold = wr_data;
        wr_req = 1'b1;
        idle(1);
        wr_req = 1'b0;
        checks++; if (wr_data !== hold) $display("FAIL %s wr_data_hold: got %h want %h", name, wr_data, hold); else passed++;
        checks++; if (rd_trig_cnt !== t_rd) $display("FAIL %s stray_rd_trig: got %0d want %0d", name, rd_trig_cnt, t_rd); else passed++;
    endtask

    task automatic run_read(input string name, input bit rnd, input bit inject);
        logic [15:0] w [BL];
        logic [7:0]  exp_b [$];
        int t_rd, t_wr, t_viol, t_drop, n;
        for (int k = 0; k < BL; k++) begin
            w[k] = rnd ? 16'($urandom) : 16'((k + 1) * 16'h1111);
            exp_b.push_back(w[k][15:8]);
            exp_b.push_back(w[k][7:0]);
        end
        t_rd = rd_trig_cnt;
        t_wr = wr_trig_cnt;
        t_viol = busy_viol;
        t_drop = drop_cnt;
        rd_data = 16'hDEAD;
        rd_valid = 1'b1;
        idle(1);
        rd_valid = 1'b0;
        tx_q.delete();
        send_byte(8'hAA);
        idle(1);
        checks++; if (rd_trig_cnt - t_rd !== 1) $display("FAIL %s rd_trig_count: got %0d want 1", name, rd_trig_cnt - t_rd); else passed++;
        for (int k = 0; k < BL; k++) begin
            idle($urandom_range(0, 2));
            rd_data = w[k];
            rd_valid = 1'b1;
            @(posedge clk);
            #1 rd_valid = 1'b0;
        end
        if (inject) begin
            n = 0;
            while (tx_q.size() < 2 && n < 500) begin
                idle(1);
                n++;
            end
            rx_data = 8'h55;
            rx_valid = 1'b1;
            #1;
            checks++; if (drop !== 1'b1) $display("FAIL %s drop_high: got %b want 1", name, drop); else passed++;
            @(posedge clk);
            #1 rx_valid = 1'b0;
            #1;
            checks++; if (drop !== 1'b0) $display("FAIL %s drop_low: got %b want 0", name, drop); else passed++;
            checks++; if (drop_cnt - t_drop !== 1) $display("FAIL %s drop_cycles: got %0d want 1", name, drop_cnt - t_drop); else passed++;
        end
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            idle(1);
            n++;
        end
        checks++; if (busy !== 1'b0) $display("FAIL %s read_done: got busy=%b want 0", name, busy); else passed++;
        checks++; if (tx_q.size() !== 2*BL) $display("FAIL %s tx_count: got %0d want %0d", name, tx_q.size(), 2*BL); else passed++;
        for (int i = 0; i < 2*BL; i++) begin
            if (i < tx_q.size()) begin
                checks++;
                if (tx_q[i] !== exp_b[i]) $display("FAIL %s tx_byte[%0d]: got %h want %h", name, i, tx_q[i], exp_b[i]);
                else passed++;
            end
        end
        checks++; if (busy_viol !== t_viol) $display("FAIL %s tx_start_while_busy: got %0d want %0d", name, busy_viol - t_viol, 0); else passed++;
        checks++; if (rd_trig_cnt - t_rd !== 1 || wr_trig_cnt !== t_wr) $display("FAIL %s trig_totals: got rd=%0d wr=%0d want rd=1 wr=0", name, rd_trig_cnt - t_rd, wr_trig_cnt - t_wr); else passed++;
    endtask

    task automatic test_timeout();
        int t_wr;
        t_wr = wr_trig_cnt;
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(TO - 1);
        checks++; if (busy !== 1'b1) $display("FAIL timeout_early: got busy=%b want 1", busy); else passed++;
        idle(1);
        checks++; if (busy !== 1'b0) $display("FAIL timeout_expire: got busy=%b want 0", busy); else passed++;
        checks++; if (wr_trig_cnt !== t_wr) $display("FAIL timeout_no_trig: got %0d want %0d", wr_trig_cnt, t_wr); else passed++;
        for (int i = 0; i < 2*BL; i++) frame[i] = 8'hAA;
        run_write("after_timeout", -1);
        for (int i = 0; i < 2*BL; i++) frame[i] = 8'($urandom);
        run_write("gap_boundary", TO - 1);
    endtask

    task automatic test_reset_mid();
        int t_wr;
        for (int i = 0; i < 2*BL; i++) frame[i] = 8'($urandom);
        send_byte(8'h55);
        for (int i = 0; i < 4; i++) send_byte(frame[i]);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
        idle(2);
        rst = 1'b0;
        t_wr = wr_trig_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        idle(2 * TO);
        checks++; if (wr_trig_cnt !== t_wr) $display("FAIL midreset_no_trig: got %0d want %0d", wr_trig_cnt, t_wr); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midreset_idle: got busy=%b want 0", busy); else passed++;
        for (int i = 0; i < 2*BL; i++) frame[i] = 8'($urandom);
        run_write("after_reset", -1);
    endtask

    task automatic test_unknown_cmd();
        int t_sum;
        t_sum = wr_trig_cnt + rd_trig_cnt + tx_start_cnt;
        rx_data = 8'h3C;
        rx_valid = 1'b1;
        #1;
        checks++; if (drop !== 1'b0) $display("FAIL unknown_drop: got %b want 0", drop); else passed++;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL unknown_busy: got %b want 0", busy); else passed++;
        idle(5);
        checks++; if (wr_trig_cnt + rd_trig_cnt + tx_start_cnt !== t_sum) $display("FAIL unknown_trig: got %0d want %0d", wr_trig_cnt + rd_trig_cnt + tx_start_cnt, t_sum); else passed++;
    endtask

    initial begin
        test_reset();
        frame = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_write("write_fixed", 0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 2*BL; i++) frame[i] = 8'($urandom);
            run_write("write_rand", -1);
        end
        run_read("read_fixed", 1'b0, 1'b0);
        run_read("read_rand", 1'b1, 1'b0);
        run_read("read_drop", 1'b1, 1'b1);
        test_timeout();
        test_reset_mid();
        test_unknown_cmd();
        checks++; if (clash_cnt !== 0) $display("FAIL trig_exclusive: got %0d overlaps want 0", clash_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
